// File: rtl/display_arbiter.sv
// display_arbiter: shares the 4-digit display between background data and two timed messages
module display_arbiter #(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bg_hexs,
    input  logic [3:0]  bg_points,
    input  logic [3:0]  bg_LEs,
    input  logic [1:0]  msg_req,
    input  logic [31:0] msg_hexs,
    input  logic [7:0]  msg_points,
    input  logic [1:0]  msg_blink,
    output logic [1:0]  msg_ack,
    output logic [1:0]  msg_done,
    output logic [15:0] hexs,
    output logic [3:0]  points,
    output logic [3:0]  LEs,
    output logic        busy,
    output logic [1:0]  cur_src
);
    typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;
    state_t state;
    logic [31:0] hold_cnt, blink_cnt;
    logic phase, blink, sel, expire, preempt, release_bg, accept, blink_wrap, next_phase;
    // accept/expiry decisions; msg1 always wins when both sources request
    always_comb begin
        sel        = msg_req[1];
        expire     = (state != IDLE) && (hold_cnt == 32'(HOLD_CYCLES - 1));
        preempt    = (state == SHOW0) && msg_req[1];
        release_bg = (state == IDLE) || expire;
        accept     = release_bg ? |msg_req : preempt;
        blink_wrap = blink_cnt == 32'(BLINK_CYCLES - 1);
        next_phase = blink_wrap ? ~phase : phase;
    end
    // arbitration FSM with all display outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            blink     <= 1'b0;
            hexs      <= '0;
            points    <= '0;
            LEs       <= 4'hF;
            msg_ack   <= '0;
            msg_done  <= '0;
            busy      <= 1'b0;
            cur_src   <= '0;
        end else begin
            msg_ack  <= '0;
            msg_done <= (expire || preempt) ? ((state == SHOW1) ? 2'b10 : 2'b01) : 2'b00;
            if (accept) begin
                state     <= sel ? SHOW1 : SHOW0;
                hexs      <= sel ? msg_hexs[31:16] : msg_hexs[15:0];
                points    <= sel ? msg_points[7:4] : msg_points[3:0];
                blink     <= sel ? msg_blink[1] : msg_blink[0];
                LEs       <= 4'h0;
                msg_ack   <= sel ? 2'b10 : 2'b01;
                busy      <= 1'b1;
                cur_src   <= sel ? 2'd2 : 2'd1;
                hold_cnt  <= '0;
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (release_bg) begin
                state     <= IDLE;
                hexs      <= bg_hexs;
                points    <= bg_points;
                LEs       <= bg_LEs;
                busy      <= 1'b0;
                cur_src   <= '0;
                hold_cnt  <= '0;
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else begin
                hold_cnt  <= hold_cnt + 32'd1;
                blink_cnt <= blink_wrap ? 32'd0 : blink_cnt + 32'd1;
                phase     <= next_phase;
                LEs       <= (blink && !next_phase) ? 4'hF : 4'h0;
            end
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed vector bench for display_arbiter with short hold/blink times
module tb_display_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bg_hexs;
    logic [3:0]  bg_points, bg_LEs;
    logic [1:0]  msg_req, msg_blink;
    logic [31:0] msg_hexs;
    logic [7:0]  msg_points;
    logic [1:0]  msg_ack, msg_done, cur_src;
    logic [15:0] hexs;
    logic [3:0]  points, LEs;
    logic        busy;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        r;
        logic [1:0]  req;
        logic [15:0] e_hexs;
        logic [3:0]  e_pts;
        logic [3:0]  e_les;
        logic [1:0]  e_ack;
        logic [1:0]  e_done;
        logic        e_busy;
        logic [1:0]  e_src;
    } vec_t;
    vec_t vecs[$];

    display_arbiter #(.HOLD_CYCLES(8), .BLINK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .bg_hexs(bg_hexs), .bg_points(bg_points), .bg_LEs(bg_LEs),
        .msg_req(msg_req), .msg_hexs(msg_hexs), .msg_points(msg_points), .msg_blink(msg_blink),
        .msg_ack(msg_ack), .msg_done(msg_done), .hexs(hexs), .points(points), .LEs(LEs),
        .busy(busy), .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] req);
        rst = r;
        msg_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [1:0] req, input logic [15:0] h, input logic [3:0] p,
                       input logic [3:0] l, input logic [1:0] a, input logic [1:0] d, input logic b,
                       input logic [1:0] s);
        vec_t v;
        v.r = r; v.req = req; v.e_hexs = h; v.e_pts = p; v.e_les = l;
        v.e_ack = a; v.e_done = d; v.e_busy = b; v.e_src = s;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        msg_req = 2'b00;
        msg_blink = 2'b00;
        bg_hexs = 16'h1234;
        bg_points = 4'h3;
        bg_LEs = 4'h0;
        msg_hexs = {16'hBEEF, 16'hDEAD};
        msg_points = {4'hA, 4'h5};
        // reset, then background one edge after rst falls
        add(1, 2'b00, 16'h0000, 4'h0, 4'hF, 2'b00, 2'b00, 0, 2'd0);
        add(1, 2'b00, 16'h0000, 4'h0, 4'hF, 2'b00, 2'b00, 0, 2'd0);
        add(0, 2'b00, 16'h1234, 4'h3, 4'h0, 2'b00, 2'b00, 0, 2'd0);
        // msg0 held exactly 8 cycles, then back to background
        add(0, 2'b01, 16'hDEAD, 4'h5, 4'h0, 2'b01, 2'b00, 1, 2'd1);
        for (int k = 0; k < 7; k++) add(0, 2'b00, 16'hDEAD, 4'h5, 4'h0, 2'b00, 2'b00, 1, 2'd1);
        add(0, 2'b00, 16'h1234, 4'h3, 4'h0, 2'b00, 2'b01, 0, 2'd0);
        // simultaneous request: msg1 first, msg0 stays pending and is taken at expiry
        add(0, 2'b11, 16'hBEEF, 4'hA, 4'h0, 2'b10, 2'b00, 1, 2'd2);
        for (int k = 0; k < 7; k++) add(0, 2'b01, 16'hBEEF, 4'hA, 4'h0, 2'b00, 2'b00, 1, 2'd2);
        add(0, 2'b01, 16'hDEAD, 4'h5, 4'h0, 2'b01, 2'b10, 1, 2'd1);
        // msg0 shown 3 cycles, then preempted by msg1
        add(0, 2'b00, 16'hDEAD, 4'h5, 4'h0, 2'b00, 2'b00, 1, 2'd1);
        add(0, 2'b00, 16'hDEAD, 4'h5, 4'h0, 2'b00, 2'b00, 1, 2'd1);
        add(0, 2'b10, 16'hBEEF, 4'hA, 4'h0, 2'b10, 2'b01, 1, 2'd2);
        for (int k = 0; k < 7; k++) add(0, 2'b00, 16'hBEEF, 4'hA, 4'h0, 2'b00, 2'b00, 1, 2'd2);
        add(0, 2'b00, 16'h1234, 4'h3, 4'h0, 2'b00, 2'b10, 0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].req);
            chk($sformatf("v%0d hexs", i), 32'(hexs), 32'(vecs[i].e_hexs));
            chk($sformatf("v%0d points", i), 32'(points), 32'(vecs[i].e_pts));
            chk($sformatf("v%0d LEs", i), 32'(LEs), 32'(vecs[i].e_les));
            chk($sformatf("v%0d ack", i), 32'(msg_ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d done", i), 32'(msg_done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d src", i), 32'(cur_src), 32'(vecs[i].e_src));
        end

        // blinking msg0: blink sampled on the ack edge only
        begin
            logic [3:0] exp_les [8] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
            msg_blink = 2'b01;
            step(0, 2'b01);
            msg_blink = 2'b00;
            chk("blink ack", 32'(msg_ack), 32'h1);
            chk("blink LEs0", 32'(LEs), 32'(exp_les[0]));
            for (int k = 1; k < 8; k++) begin
                step(0, 2'b00);
                chk($sformatf("blink LEs%0d", k), 32'(LEs), 32'(exp_les[k]));
                chk($sformatf("blink points%0d", k), 32'(points), 32'h5);
                chk($sformatf("blink hexs%0d", k), 32'(hexs), 32'hDEAD);
            end
            step(0, 2'b00);
            chk("blink done", 32'(msg_done), 32'h1);
            chk("blink bg LEs", 32'(LEs), 32'h0);
        end

        // reset in the middle of msg1: no done pulse, background afterwards
        step(0, 2'b10);
        chk("rst ack1", 32'(msg_ack), 32'h2);
        for (int k = 0; k < 3; k++) step(0, 2'b00);
        step(1, 2'b00);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst src", 32'(cur_src), 32'h0);
        chk("rst LEs", 32'(LEs), 32'hF);
        chk("rst hexs", 32'(hexs), 32'h0);
        chk("rst done", 32'(msg_done), 32'h0);
        for (int k = 0; k < 9; k++) begin
            step(0, 2'b00);
            chk($sformatf("post rst hexs%0d", k), 32'(hexs), 32'h1234);
            chk($sformatf("post rst LEs%0d", k), 32'(LEs), 32'h0);
            chk($sformatf("post rst done%0d", k), 32'(msg_done), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
